// File: rtl/ow_pkg.sv
// Shared definitions for the 1-wire transmit path: state encoding, bit order
// and default word size.
package ow_pkg;

    localparam int unsigned OW_WORD_W = 64;
    localparam int unsigned OW_IDX_W  = 7;
    localparam bit          LSB_FIRST = 1'b1;

    // 4-bit state codes, kept in step with the output driver's encoding
    localparam logic [3:0] ST_IDLE     = 4'd0;
    localparam logic [3:0] ST_START    = 4'd1;
    localparam logic [3:0] ST_WAIT_RST = 4'd2;
    localparam logic [3:0] ST_DRV_RST  = 4'd3;
    localparam logic [3:0] ST_SEND     = 4'd4;
    localparam logic [3:0] ST_WAIT_ALL = 4'd5;

    typedef enum logic [3:0] {
        S_IDLE     = ST_IDLE,
        S_START    = ST_START,
        S_WAIT_RST = ST_WAIT_RST,
        S_DRV_RST  = ST_DRV_RST,
        S_SEND     = ST_SEND,
        S_WAIT_ALL = ST_WAIT_ALL
    } tx_state_e;

    typedef struct packed {
        logic busy;
        logic done_reset;
        logic done_1bit;
        logic done_all;
    } drv_status_t;

endpackage

// File: rtl/ow_tx_serializer.sv
// Feeds a parallel word to the 1-wire output driver: requests a bus reset,
// then hands the word over one bit per write slot via serial/strobe/done.
module ow_tx_serializer
    import ow_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = OW_WORD_W,
    parameter int unsigned IDX_W      = OW_IDX_W
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  i_load,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_ready,
    output logic                  o_start,
    output logic                  o_serial,
    output logic                  o_bit_strobe,
    input  logic                  i_drv_busy,
    input  logic                  i_done_reset,
    input  logic                  i_done_1bit,
    input  logic                  i_done_64bits,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_no_presence
);

    localparam logic [IDX_W-1:0] IDX_END  = IDX_W'(DATA_WIDTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

    tx_state_e             r_state;
    logic [DATA_WIDTH-1:0] r_data;
    logic [IDX_W-1:0]      r_idx;
    logic                  r_rst_seen;
    logic                  r_ready;
    logic                  r_start;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_no_presence;

    drv_status_t           w_drv;
    logic                  w_idx_valid;
    logic [IDX_W-1:0]      w_sel_idx;
    logic                  w_sel_bit;
    logic                  w_serial;
    logic                  w_strobe;

    always_comb begin
        w_drv.busy       = i_drv_busy;
        w_drv.done_reset = i_done_reset;
        w_drv.done_1bit  = i_done_1bit;
        w_drv.done_all   = i_done_64bits;
    end

    assign w_idx_valid = (r_idx < IDX_END);
    assign w_sel_idx   = LSB_FIRST ? r_idx : (LAST_IDX - r_idx);

    // Bit-select mux; index width is decoupled from the data width
    always_comb begin
        w_sel_bit = 1'b0;
        for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
            if (w_sel_idx == IDX_W'(i)) begin
                w_sel_bit = r_data[i];
            end
        end
    end

    // Line idles high; the driver samples bit 0 while in its DONE_RESET state
    always_comb begin
        w_serial = 1'b1;
        if ((r_state == S_DRV_RST || r_state == S_SEND) && w_idx_valid) begin
            w_serial = w_sel_bit;
        end
    end

    // Strobe tells the driver another slot follows; withheld after the last bit
    assign w_strobe = (r_state == S_SEND) && w_drv.done_1bit && w_idx_valid;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= S_IDLE;
            r_data        <= '0;
            r_idx         <= '0;
            r_rst_seen    <= 1'b0;
            r_ready       <= 1'b1;
            r_start       <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_no_presence <= 1'b0;
        end else begin
            r_start       <= 1'b0;
            r_done        <= 1'b0;
            r_no_presence <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_load) begin
                        r_data  <= i_data;
                        r_idx   <= '0;
                        r_start <= 1'b1;
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    r_rst_seen <= 1'b0;
                    r_state    <= S_WAIT_RST;
                end
                S_WAIT_RST: begin
                    if (w_drv.busy) begin
                        r_rst_seen <= 1'b1;
                    end
                    // done_reset takes priority over a simultaneous busy fall
                    if (w_drv.done_reset) begin
                        r_state <= S_DRV_RST;
                    end else if (r_rst_seen && !w_drv.busy) begin
                        r_no_presence <= 1'b1;
                        r_ready       <= 1'b1;
                        r_busy        <= 1'b0;
                        r_state       <= S_IDLE;
                    end
                end
                S_DRV_RST: begin
                    r_idx   <= IDX_W'(1);
                    r_state <= S_SEND;
                end
                S_SEND: begin
                    if (w_drv.done_1bit) begin
                        if (w_idx_valid) begin
                            r_idx <= r_idx + IDX_W'(1);
                        end else begin
                            r_state <= S_WAIT_ALL;
                        end
                    end else if (!w_drv.busy) begin
                        r_no_presence <= 1'b1;
                        r_ready       <= 1'b1;
                        r_busy        <= 1'b0;
                        r_state       <= S_IDLE;
                    end
                end
                S_WAIT_ALL: begin
                    if (w_drv.done_all) begin
                        r_done  <= 1'b1;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_ready       = r_ready;
    assign o_start       = r_start;
    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_no_presence = r_no_presence;
    assign o_serial      = w_serial;
    assign o_bit_strobe  = w_strobe;

endmodule

// File: tb/tb_ow_tx_serializer.sv
// Directed bench for ow_tx_serializer with a cycle-level model of the output driver.
module tb_ow_tx_serializer;

    logic        clk;
    logic        reset_n;

    logic        load, ready, start, serial, strobe, drv_busy;
    logic        done_reset, done_1bit, done_64, busy, done, nopres;
    logic [63:0] data;

    logic        s_load, s_ready, s_start, s_serial, s_strobe, s_drv_busy;
    logic        s_done_reset, s_done_1bit, s_done_64, s_busy, s_done, s_nopres;
    logic        s_data;

    int n_checks;
    int n_err;

    logic [63:0] r_bits;
    int r_slots, r_strobes, r_starts, r_dones, r_nopres, r_both;
    int r_start_cyc, r_last_cyc, r_done_cyc;
    bit r_timeout;

    ow_tx_serializer #(.DATA_WIDTH(64), .IDX_W(7)) dut (
        .clk(clk), .reset_n(reset_n), .i_load(load), .i_data(data),
        .o_ready(ready), .o_start(start), .o_serial(serial), .o_bit_strobe(strobe),
        .i_drv_busy(drv_busy), .i_done_reset(done_reset), .i_done_1bit(done_1bit),
        .i_done_64bits(done_64), .o_busy(busy), .o_done(done), .o_no_presence(nopres)
    );

    ow_tx_serializer #(.DATA_WIDTH(1), .IDX_W(2)) dut_w1 (
        .clk(clk), .reset_n(reset_n), .i_load(s_load), .i_data(s_data),
        .o_ready(s_ready), .o_start(s_start), .o_serial(s_serial), .o_bit_strobe(s_strobe),
        .i_drv_busy(s_drv_busy), .i_done_reset(s_done_reset), .i_done_1bit(s_done_1bit),
        .i_done_64bits(s_done_64), .o_busy(s_busy), .o_done(s_done), .o_no_presence(s_nopres)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Driver model: reset phase, slots of 3 cycles, done_all handshake.
    task automatic run_txn(input logic [63:0] d, input bit presence, input int reload_at,
                           input logic [63:0] rdata, input int abort_at);
        int ph;
        int cnt;
        int tail;
        bit reloaded;
        r_bits = '0; r_slots = 0; r_strobes = 0; r_starts = 0; r_dones = 0;
        r_nopres = 0; r_both = 0; r_start_cyc = -1; r_last_cyc = -1; r_done_cyc = -1;
        r_timeout = 1'b1;
        ph = 0; cnt = 0; tail = 0; reloaded = 1'b0;
        @(negedge clk);
        load = 1'b1;
        data = d;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            load = 1'b0;
            done_reset = 1'b0;
            done_1bit = 1'b0;
            done_64 = 1'b0;
            if (start) begin
                r_starts++;
                if (r_start_cyc < 0) r_start_cyc = cyc;
            end
            if (done) begin
                r_dones++;
                r_done_cyc = cyc;
            end
            if (nopres) r_nopres++;
            if (done && nopres) r_both++;
            case (ph)
                0: if (start) begin ph = 1; cnt = 4; end
                1: begin
                    drv_busy = 1'b1;
                    cnt--;
                    if (cnt == 0) begin
                        if (presence) begin
                            done_reset = 1'b1;
                            ph = 2;
                        end else begin
                            drv_busy = 1'b0;
                            ph = 9;
                        end
                    end
                end
                2: begin
                    r_bits[0] = serial;
                    r_slots = 1;
                    cnt = 3;
                    ph = 3;
                end
                3: begin
                    if (r_slots == abort_at) begin
                        reset_n = 1'b0;
                        drv_busy = 1'b0;
                        #1;
                        check("abort_outputs", {57'd0, ready, busy, start, serial, strobe, done, nopres},
                              {57'd0, 7'b1001000});
                        check("abort_partial_bits", r_bits & 64'hF_FFFF, d & 64'hF_FFFF);
                        @(negedge clk);
                        reset_n = 1'b1;
                        r_timeout = 1'b0;
                        break;
                    end
                    if (r_slots == reload_at && !reloaded) begin
                        load = 1'b1;
                        data = rdata;
                        reloaded = 1'b1;
                    end
                    cnt--;
                    if (cnt == 0) begin
                        done_1bit = 1'b1;
                        #1;
                        if (strobe) begin
                            r_strobes++;
                            if (r_slots < 64) r_bits[r_slots] = serial;
                            r_slots++;
                            cnt = 3;
                        end else begin
                            r_last_cyc = cyc;
                            ph = 5;
                        end
                    end
                end
                5: begin done_64 = 1'b1; ph = 6; end
                6: begin drv_busy = 1'b0; ph = 9; end
                default: begin
                    tail++;
                    if (tail == 3) begin
                        r_timeout = 1'b0;
                        break;
                    end
                end
            endcase
        end
        load = 1'b0;
        done_reset = 1'b0;
        done_1bit = 1'b0;
        done_64 = 1'b0;
        drv_busy = 1'b0;
    endtask

    typedef struct {
        logic [63:0] data;
        bit          presence;
        int          reload_at;
        logic [63:0] reload_data;
        logic [63:0] exp_bits;
        int          exp_slots;
        int          exp_strobes;
        int          exp_dones;
        int          exp_nopres;
    } vec_t;

    vec_t vecs[6];

    initial begin
        n_checks = 0;
        n_err = 0;
        vecs[0] = '{64'h0000_0000_0000_00CC, 1'b1, -1, 64'h0, 64'h0000_0000_0000_00CC, 64, 63, 1, 0};
        vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 1'b1, -1, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64, 63, 1, 0};
        vecs[2] = '{64'h0123_4567_89AB_CDEF, 1'b0, -1, 64'h0, 64'h0, 0, 0, 0, 1};
        vecs[3] = '{64'h8000_0000_0000_0001, 1'b1, -1, 64'h0, 64'h8000_0000_0000_0001, 64, 63, 1, 0};
        vecs[4] = '{64'hA5A5_5A5A_0F0F_F0F0, 1'b1, 10, 64'h5555_5555_5555_5555,
                    64'hA5A5_5A5A_0F0F_F0F0, 64, 63, 1, 0};
        vecs[5] = '{64'h0000_0000_0000_0000, 1'b1, 40, 64'hFFFF_FFFF_FFFF_FFFF,
                    64'h0000_0000_0000_0000, 64, 63, 1, 0};

        reset_n = 1'b0;
        load = 1'b0; data = '0; drv_busy = 1'b0;
        done_reset = 1'b0; done_1bit = 1'b0; done_64 = 1'b0;
        s_load = 1'b0; s_data = 1'b0; s_drv_busy = 1'b0;
        s_done_reset = 1'b0; s_done_1bit = 1'b0; s_done_64 = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready", ready, 1);
        check("rst_start", start, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_nopres", nopres, 0);
        check("rst_strobe", strobe, 0);
        check("rst_serial", serial, 1);
        check("rst_w1_ready", s_ready, 1);
        reset_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            run_txn(vecs[i].data, vecs[i].presence, vecs[i].reload_at, vecs[i].reload_data, -1);
            check($sformatf("v%0d_timeout", i), r_timeout, 0);
            check($sformatf("v%0d_bits", i), r_bits, vecs[i].exp_bits);
            check($sformatf("v%0d_slots", i), r_slots, vecs[i].exp_slots);
            check($sformatf("v%0d_strobes", i), r_strobes, vecs[i].exp_strobes);
            check($sformatf("v%0d_starts", i), r_starts, 1);
            check($sformatf("v%0d_start_lat", i), r_start_cyc, 0);
            check($sformatf("v%0d_dones", i), r_dones, vecs[i].exp_dones);
            check($sformatf("v%0d_nopres", i), r_nopres, vecs[i].exp_nopres);
            check($sformatf("v%0d_both", i), r_both, 0);
            check($sformatf("v%0d_ready_after", i), ready, 1);
            check($sformatf("v%0d_busy_after", i), busy, 0);
            if (vecs[i].presence)
                check($sformatf("v%0d_done_lat", i), r_done_cyc - r_last_cyc, 2);
        end

        // Reset asserted while bit 20 is on the wire, then a clean transaction
        run_txn(64'h0F1E_2D3C_4B5A_6978, 1'b1, -1, 64'h0, 20);
        check("abort_timeout", r_timeout, 0);
        check("abort_ready", ready, 1);
        run_txn(64'hDEAD_BEEF_CAFE_F00D, 1'b1, -1, 64'h0, -1);
        check("post_abort_timeout", r_timeout, 0);
        check("post_abort_bits", r_bits, 64'hDEAD_BEEF_CAFE_F00D);
        check("post_abort_dones", r_dones, 1);
        check("post_abort_strobes", r_strobes, 63);

        // done_reset coincides with busy fall, then the driver vanishes mid-SEND
        @(negedge clk); load = 1'b1; data = 64'h2;
        @(negedge clk); load = 1'b0;
        check("sim_start", start, 1);
        @(negedge clk); drv_busy = 1'b1;
        @(negedge clk); drv_busy = 1'b0; done_reset = 1'b1;
        @(negedge clk); done_reset = 1'b0; drv_busy = 1'b1;
        check("sim_dr_wins_nopres", nopres, 0);
        check("sim_dr_wins_busy", busy, 1);
        check("sim_bit0", serial, 0);
        @(negedge clk);
        check("sim_bit1", serial, 1);
        drv_busy = 1'b0;
        @(negedge clk);
        check("lost_nopres", nopres, 1);
        check("lost_done", done, 0);
        check("lost_ready", ready, 1);
        check("lost_busy", busy, 0);
        @(negedge clk);
        check("lost_nopres_one_cycle", nopres, 0);

        // Single-bit instance: bit 0 goes out in DRV_RST, no strobe ever
        @(negedge clk); s_load = 1'b1; s_data = 1'b1;
        @(negedge clk); s_load = 1'b0;
        check("w1_start", s_start, 1);
        @(negedge clk); s_drv_busy = 1'b1;
        check("w1_start_one_cycle", s_start, 0);
        @(negedge clk); s_done_reset = 1'b1;
        @(negedge clk); s_done_reset = 1'b0;
        check("w1_bit0", s_serial, 1);
        check("w1_strobe_drvrst", s_strobe, 0);
        @(negedge clk); s_done_1bit = 1'b1;
        #1;
        check("w1_strobe_last", s_strobe, 0);
        @(negedge clk); s_done_1bit = 1'b0; s_done_64 = 1'b1;
        check("w1_done_early", s_done, 0);
        check("w1_busy_waitall", s_busy, 1);
        @(negedge clk); s_done_64 = 1'b0; s_drv_busy = 1'b0;
        check("w1_done", s_done, 1);
        check("w1_ready", s_ready, 1);
        check("w1_busy_after", s_busy, 0);
        @(negedge clk);
        check("w1_done_one_cycle", s_done, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/ow_tx_serializer.md
Name: ow_tx_serializer

Overview:
- Upstream feeder for the 1-wire master output driver.
- Accepts a parallel command/data word. Requests a bus reset, then presents the word LSB-first one bit per write slot, using the driver's serial/strobe/done handshake.
- Reports completion or presence failure to the command sequencer above it.

Parameters:
- DATA_WIDTH, 64, bits per transaction (1..64).
- IDX_W, 7, width of bit index; must satisfy 2**IDX_W > DATA_WIDTH.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- i_load  in  1  load request; accepted only when o_ready=1.
- i_data  in  DATA_WIDTH  word to transmit, LSB first.
- o_ready  out  1  high in IDLE only.
- o_start  out  1  one-cycle pulse to driver i_start.
- o_serial  out  1  current bit to driver i_serial.
- o_bit_strobe  out  1  to driver i_bit_strobe: another bit follows.
- i_drv_busy  in  1  driver o_busy.
- i_done_reset  in  1  driver o_done_reset.
- i_done_1bit  in  1  driver o_done_1bit.
- i_done_64bits  in  1  driver o_done_64bits.
- o_busy  out  1  transaction in progress (not IDLE).
- o_done  out  1  one-cycle pulse: all bits sent.
- o_no_presence  out  1  one-cycle pulse: reset completed without presence.

Behaviour:
- Reset (reset_n=0, async): state=IDLE, data_reg=0, idx=0, rst_seen=0. Outputs: o_ready=1, o_start=0, o_busy=0, o_done=0, o_no_presence=0, o_bit_strobe=0, o_serial=1.
- States: IDLE, START, WAIT_RST, DRV_RST, SEND, WAIT_ALL.
- IDLE:
  - i_load=1 latches i_data into data_reg, idx=0 → START.
  - i_load while not IDLE is ignored; no queueing.
- START: registered o_start=1 for exactly one cycle; rst_seen cleared → WAIT_RST.
- WAIT_RST:
  - rst_seen set when i_drv_busy=1.
  - i_done_reset=1 → DRV_RST.
  - Else if rst_seen=1 and i_drv_busy=0: pulse o_no_presence next cycle → IDLE.
- DRV_RST:
  - One cycle; driver is in its DONE_RESET state and samples o_serial = data_reg[0].
  - At cycle end idx ← 1 → SEND.
- SEND:
  - o_serial = data_reg[idx] when idx < DATA_WIDTH, else 1 (combinational from registers).
  - o_bit_strobe = i_done_1bit && (idx < DATA_WIDTH), combinational, same cycle as i_done_1bit.
  - i_done_1bit with idx < DATA_WIDTH: idx ← idx+1, stay.
  - i_done_1bit with idx == DATA_WIDTH: strobe stays 0 → WAIT_ALL.
  - i_drv_busy=0 without i_done_1bit: o_no_presence pulse → IDLE (driver lost, error path).
- WAIT_ALL: i_done_64bits=1 → o_done pulse next cycle → IDLE. o_start is never asserted here, so the driver returns to idle.
- DATA_WIDTH=1: first i_done_1bit sees idx==1 → no strobe → WAIT_ALL.
- Latency:
  - i_load to o_start: 1 cycle.
  - Last i_done_1bit to o_done: 2 cycles (via WAIT_ALL).
- o_busy = (state != IDLE), registered.
- o_done and o_no_presence are never both high; each is exactly one cycle.
- Reset mid-transaction aborts immediately to IDLE; the driver is reset from the same source.
- Simultaneous i_done_reset and i_drv_busy fall in WAIT_RST: done_reset wins.

Decomposition:
- Shared package ow_pkg:
  - state encoding localparams (4-bit, like the driver's);
  - LSB_FIRST convention constant;
  - OW_WORD_W=64.
- No sub-module; a single FSM plus index counter and data register.
- Optional ow_tx_serializer_tb pairs this block with the output driver and a 1-wire slave model.

Test Plan:
- Load 64'h0000_0000_0000_00CC with the slave answering presence → 1-cycle o_start; write slots 0,0,1,1,0,0,1,1 then 56 zeros; 63 o_bit_strobe pulses; o_done once; o_busy low afterwards.
- Load 64'hFFFF_FFFF_FFFF_FFFF → 64 write-1 slots; driver reaches done-all; o_done=1 one cycle.
- No slave on bus → o_no_presence pulse after driver busy drops; no write slots; o_done never asserts; o_ready=1.
- i_load asserted again during SEND with a different word → ignored; transmitted bits match the first word.
- reset_n pulsed low mid-SEND at bit 20 → all outputs at reset values immediately; bus released; a fresh load afterwards transmits correctly.
- DATA_WIDTH=1, i_data=1 → one write-1 slot, o_bit_strobe never high, o_done asserted.
